// File: rtl/branch_predictor.sv
// Fetch-stage direction/target predictor: direct-mapped 2-bit counters with a
// tagged target buffer, registered lookup, and a saturating mispredict counter.
module branch_predictor #(
   parameter int unsigned INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        lookup_valid_in,
   input  logic [63:0] lookup_pc_in,
   output logic        pred_valid_out,
   output logic        pred_taken_out,
   output logic [63:0] pred_target_out,
   input  logic        update_valid_in,
   input  logic [63:0] update_pc_in,
   input  logic        update_taken_in,
   input  logic [63:0] update_target_in,
   input  logic        update_mispredicted_in,
   output logic [31:0] mispredict_count_out
);

   localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
   localparam int unsigned TAG_BITS = 62 - INDEX_BITS;

   logic                valid  [ENTRIES];
   logic [TAG_BITS-1:0] tag    [ENTRIES];
   logic [1:0]          ctr    [ENTRIES];
   logic [61:0]         target [ENTRIES];

   logic [INDEX_BITS-1:0] lk_idx;
   logic [TAG_BITS-1:0]   lk_tag;
   logic                  lk_hit;
   logic                  lk_taken;
   logic [63:0]           lk_target;

   logic [INDEX_BITS-1:0] up_idx;
   logic [TAG_BITS-1:0]   up_tag;
   logic                  up_hit;

   logic [31:0] mis_count;

   // Low PC/target bits are word-offset bits and carry no information here.
   logic unused_bits;
   assign unused_bits = ^{lookup_pc_in[1:0], update_pc_in[1:0], update_target_in[1:0]};

   always_comb begin
      lk_idx    = lookup_pc_in[INDEX_BITS+1:2];
      lk_tag    = lookup_pc_in[63:INDEX_BITS+2];
      lk_hit    = valid[lk_idx] && (tag[lk_idx] == lk_tag);
      lk_taken  = lk_hit && ctr[lk_idx][1];
      lk_target = lk_hit ? {target[lk_idx], 2'b00}
                         : {lookup_pc_in[63:2] + 62'd1, 2'b00};
   end

   always_comb begin
      up_idx = update_pc_in[INDEX_BITS+1:2];
      up_tag = update_pc_in[63:INDEX_BITS+2];
      up_hit = valid[up_idx] && (tag[up_idx] == up_tag);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pred_valid_out  <= 1'b0;
         pred_taken_out  <= 1'b0;
         pred_target_out <= '0;
      end else begin
         pred_valid_out <= lookup_valid_in;
         if (lookup_valid_in) begin
            pred_taken_out  <= lk_taken;
            pred_target_out <= lk_target;
         end else begin
            pred_taken_out  <= 1'b0;
         end
      end
   end

   // Lookup above reads the pre-edge table, which gives read-before-write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            tag[i]    <= '0;
            ctr[i]    <= 2'b01;
            target[i] <= '0;
         end
      end else if (update_valid_in) begin
         if (up_hit) begin
            if (update_taken_in) begin
               if (ctr[up_idx] != 2'b11) ctr[up_idx] <= ctr[up_idx] + 2'd1;
               target[up_idx] <= update_target_in[63:2];
            end else if (ctr[up_idx] != 2'b00) begin
               ctr[up_idx] <= ctr[up_idx] - 2'd1;
            end
         end else if (update_taken_in) begin
            valid[up_idx]  <= 1'b1;
            tag[up_idx]    <= up_tag;
            ctr[up_idx]    <= 2'b10;
            target[up_idx] <= update_target_in[63:2];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mis_count <= '0;
      end else if (update_valid_in && update_mispredicted_in && (mis_count != '1)) begin
         mis_count <= mis_count + 32'd1;
      end
   end

   assign mispredict_count_out = mis_count;

endmodule
